// File: rtl/fetch_unit_pkg.sv
// Shared types and sizing for the fetch front-end.
package fetch_unit_pkg;

  localparam int unsigned N               = 2;
  localparam int unsigned NUM_SCALAR_BITS = $clog2(N + 1);
  localparam int unsigned BLOCK_BYTES     = N * 4;
  localparam int unsigned OFF_W           = (N > 1) ? $clog2(N) : 1;
  localparam logic [31:0] BLOCK_MASK      = ~(32'(BLOCK_BYTES) - 32'd1);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } FETCH_PACKET;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DELIVER,
    SQUASH
  } FETCH_STATE;

  // Block-aligned base address of the block containing pc.
  function automatic logic [31:0] block_addr(input logic [31:0] pc);
    return pc & BLOCK_MASK;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Redirect, I-cache and instruction-buffer signals of the fetch unit.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic                        restore_valid;
  logic [31:0]                 restore_pc;
  logic                        icache_req_valid;
  logic [31:0]                 icache_req_addr;
  logic                        icache_req_ready;
  logic                        icache_rsp_valid;
  logic [N*32-1:0]             icache_rsp_data;
  logic [NUM_SCALAR_BITS-1:0]  inst_buffer_spots;
  FETCH_PACKET [N-1:0]         inst_buffer_inputs;
  logic [NUM_SCALAR_BITS-1:0]  inst_valid;

  // Fetch unit side.
  modport master (
    input  restore_valid, restore_pc, icache_req_ready, icache_rsp_valid,
           icache_rsp_data, inst_buffer_spots,
    output icache_req_valid, icache_req_addr, inst_buffer_inputs, inst_valid
  );

  // Cache / buffer / branch-stack side.
  modport slave (
    output restore_valid, restore_pc, icache_req_ready, icache_rsp_valid,
           icache_rsp_data, inst_buffer_spots,
    input  icache_req_valid, icache_req_addr, inst_buffer_inputs, inst_valid
  );

endinterface

// File: rtl/fetch_unit_slot_select.sv
// Maps the staged block, start offset and delivery count onto the output slots.
module fetch_slot_select
  import fetch_unit_pkg::*;
(
  input  logic [N*32-1:0]            staging_i,
  input  logic [31:0]                pc_i,
  input  logic [OFF_W-1:0]           offset_i,
  input  logic [NUM_SCALAR_BITS-1:0] count_i,
  output FETCH_PACKET [N-1:0]        slots_o
);

  // Slot k carries word offset+k; unused slots stay zero.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    slots_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (k < 32'(count_i)) begin
        idx = 32'(offset_i) + k;
        if (idx < N) slots_o[k].inst = staging_i[idx*32 +: 32];
        slots_o[k].PC  = pc_i + 32'(k * 4);
        slots_o[k].NPC = pc_i + 32'(k * 4) + 32'd4;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential-PC fetch unit: one block request at a time, credit-limited delivery.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clock,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  FETCH_STATE                  state_q, state_d;
  logic [31:0]                 pc_q, pc_d;
  logic [N*32-1:0]             staging_q, staging_d;
  logic                        req_valid;
  logic [OFF_W-1:0]            offset;
  logic [NUM_SCALAR_BITS-1:0]  avail;
  logic [NUM_SCALAR_BITS-1:0]  count;
  logic                        outstanding_after;

  assign offset = pc_q[OFF_W+1:2];
  assign avail  = NUM_SCALAR_BITS'(N) - NUM_SCALAR_BITS'(offset);

  // Next-state, PC advance and delivery count; restore overrides, reset masks outputs.
  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    staging_d         = staging_q;
    req_valid         = 1'b0;
    count             = '0;
    outstanding_after = 1'b0;

    case (state_q)
      REQ: begin
        req_valid = 1'b1;
        if (bus.icache_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.icache_rsp_valid) begin
          state_d   = DELIVER;
          staging_d = bus.icache_rsp_data;
        end
      end
      DELIVER: begin
        count = (bus.inst_buffer_spots < avail) ? bus.inst_buffer_spots : avail;
        pc_d  = pc_q + (32'(count) << 2);
        if (count == avail) state_d = REQ;
      end
      SQUASH: begin
        if (bus.icache_rsp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    // A request accepted in the restore cycle is stale, so it must be squashed too.
    if (bus.restore_valid) begin
      outstanding_after = ((state_q == WAIT || state_q == SQUASH) && !bus.icache_rsp_valid)
                        || (state_q == REQ && bus.icache_req_ready);
      count     = '0;
      pc_d      = bus.restore_pc;
      staging_d = staging_q;
      state_d   = outstanding_after ? SQUASH : REQ;
    end

    if (!reset) begin
      req_valid = 1'b0;
      count     = '0;
    end
  end

  // State, PC and staging registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      staging_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      staging_q <= staging_d;
    end
  end

  assign bus.icache_req_valid = req_valid;
  assign bus.icache_req_addr  = block_addr(pc_q);
  assign bus.inst_valid       = count;

  fetch_slot_select u_slot_select (
    .staging_i (staging_q),
    .pc_i      (pc_q),
    .offset_i  (offset),
    .count_i   (count),
    .slots_o   (bus.inst_buffer_inputs)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against an instruction-stream reference model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Contents of instruction memory as seen through the cache.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: next PC the buffer should receive, plus cache/ownership flags.
  logic [31:0] m_pc;
  bit          have_block;   // a live block is held and not yet drained
  bit          outst;        // a request is in flight at the cache
  bit          stale;        // in-flight request predates a restore
  int unsigned delay;
  logic [31:0] out_addr;

  int unsigned avail, exp_iv, spots;
  bit          restore, ready, rsp, exp_req, accept;
  logic [31:0] rpc, p, exp_addr;
  FETCH_PACKET exp_pkt;

  initial begin
    m_pc = '0; have_block = 0; outst = 0; stale = 0; delay = 0; out_addr = '0;
    reset = 1'b0;
    bus.restore_valid = 1'b0; bus.restore_pc = '0; bus.icache_req_ready = 1'b0;
    bus.icache_rsp_valid = 1'b0; bus.icache_rsp_data = '0; bus.inst_buffer_spots = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      reset = !(cyc < 2 || (cyc >= 1500 && cyc < 1502));

      restore = reset && ($urandom_range(0, 19) == 0);
      rpc     = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)))
                                            : 32'(4 * $urandom_range(0, 127));
      ready   = ($urandom_range(0, 3) != 0);
      spots   = $urandom_range(0, N);
      rsp     = outst && (delay == 0);

      bus.restore_valid     = restore;
      bus.restore_pc        = rpc;
      bus.icache_req_ready  = ready;
      bus.inst_buffer_spots = NUM_SCALAR_BITS'(spots);
      bus.icache_rsp_valid  = rsp;
      for (int i = 0; i < N; i++)
        bus.icache_rsp_data[i*32 +: 32] = !rsp ? $urandom()
                                        : stale ? ~mem_word(out_addr + 32'(4 * i))
                                        : mem_word(out_addr + 32'(4 * i));
      #1;

      if (!reset) begin
        check_eq("rst_req_valid", 96'(bus.icache_req_valid), 96'(0));
        check_eq("rst_inst_valid", 96'(bus.inst_valid), 96'(0));
        for (int k = 0; k < N; k++)
          check_eq("rst_slot", 96'(bus.inst_buffer_inputs[k]), 96'(0));
        m_pc = '0; have_block = 0; outst = 0; stale = 0; delay = 0;
        continue;
      end

      // Expected delivery: min(words left in block, free slots) while a live block is held.
      avail  = N - ((m_pc >> 2) % N);
      exp_iv = (have_block && !restore) ? ((spots < avail) ? spots : avail) : 0;
      check_eq("inst_valid", 96'(bus.inst_valid), 96'(exp_iv));
      for (int k = 0; k < N; k++) begin
        if (k < int'(exp_iv)) begin
          p = m_pc + 32'(4 * k);
          exp_pkt.inst = mem_word(p);
          exp_pkt.PC   = p;
          exp_pkt.NPC  = p + 32'd4;
          check_eq("slot_pkt", 96'(bus.inst_buffer_inputs[k]), 96'(exp_pkt));
        end else begin
          check_eq("slot_zero", 96'(bus.inst_buffer_inputs[k]), 96'(0));
        end
      end

      exp_req  = !have_block && !outst;
      exp_addr = m_pc & ~(32'(N * 4) - 32'd1);
      check_eq("req_valid", 96'(bus.icache_req_valid), 96'(exp_req));
      if (exp_req)
        check_eq("req_addr", 96'(bus.icache_req_addr), 96'(exp_addr));

      // Advance the model across the coming edge.
      accept = exp_req && ready;
      if (have_block && !restore) begin
        m_pc = m_pc + 32'(4 * exp_iv);
        if (exp_iv == avail) have_block = 0;
      end
      if (rsp) begin
        outst = 0;
        if (!stale && !restore) have_block = 1;
      end else if (outst && delay > 0) begin
        delay--;
      end
      if (accept) begin
        outst    = 1;
        stale    = 0;
        delay    = $urandom_range(0, 3);
        out_addr = exp_addr;
      end
      if (restore) begin
        m_pc       = rpc;
        have_block = 0;
        if (outst) stale = 1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
